// File: rtl/uart_rx.sv
// UART receiver: start/data/optional parity/stop framing with per-frame latched PRESCALE.
// Define RX_SYNC_EN to add a two-flop input synchronizer on RX_IN (adds 2 cycles of latency).
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            PRESCALE,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR,
    output logic [2:0]            cs_out
);

    localparam logic [2:0] IDLE   = 3'b000;
    localparam logic [2:0] START  = 3'b001;
    localparam logic [2:0] DATA   = 3'b011;
    localparam logic [2:0] PARITY = 3'b010;
    localparam logic [2:0] STOP   = 3'b110;

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [2:0]            r_state;
    logic [5:0]            r_edgeCnt;
    logic [BCW-1:0]        r_bitCnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [5:0]            r_prescale;
    logic                  r_parEn;
    logic                  r_parTyp;
    logic                  r_parFlag;
    logic                  r_stpFlag;

    logic                  w_rx;
    logic [5:0]            w_prescaleLegal;
    logic                  w_midBit;
    logic                  w_bitEnd;
    logic [5:0]            w_edgeNext;

`ifdef RX_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge clk) begin
        if (RST) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], RX_IN};
        end
    end

    assign w_rx = r_sync[1];
`else
    assign w_rx = RX_IN;
`endif

    // Unsupported oversampling ratios fall back to 8 so a bad setting still frames cleanly.
    always_comb begin
        w_prescaleLegal = 6'd8;
        case (PRESCALE)
            6'd8, 6'd16, 6'd32: w_prescaleLegal = PRESCALE;
            default:            w_prescaleLegal = 6'd8;
        endcase
    end

    assign w_midBit   = (r_edgeCnt == (r_prescale >> 1));
    assign w_bitEnd   = (r_edgeCnt == (r_prescale - 6'd1));
    assign w_edgeNext = w_bitEnd ? 6'd0 : (r_edgeCnt + 6'd1);
    assign cs_out     = r_state;

    always_ff @(posedge clk) begin
        if (RST) begin
            r_state    <= IDLE;
            r_edgeCnt  <= 6'd0;
            r_bitCnt   <= '0;
            r_shift    <= '0;
            r_prescale <= 6'd8;
            r_parEn    <= 1'b0;
            r_parTyp   <= 1'b0;
            r_parFlag  <= 1'b0;
            r_stpFlag  <= 1'b0;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
            case (r_state)
                IDLE: begin
                    // The detecting cycle counts as edge 0 of the start bit, hence edge_cnt starts at 1.
                    if (!w_rx) begin
                        r_state    <= START;
                        r_edgeCnt  <= 6'd1;
                        r_bitCnt   <= '0;
                        r_prescale <= w_prescaleLegal;
                        r_parEn    <= PAR_EN;
                        r_parTyp   <= PAR_TYP;
                        r_parFlag  <= 1'b0;
                        r_stpFlag  <= 1'b0;
                    end
                end
                START: begin
                    if (w_midBit && w_rx) begin
                        r_state   <= IDLE;
                        r_edgeCnt <= 6'd0;
                    end else begin
                        r_edgeCnt <= w_edgeNext;
                        if (w_bitEnd) begin
                            r_state <= DATA;
                        end
                    end
                end
                DATA: begin
                    r_edgeCnt <= w_edgeNext;
                    if (w_midBit) begin
                        r_shift <= DATA_WIDTH'({w_rx, r_shift} >> 1);
                    end
                    if (w_bitEnd) begin
                        if (r_bitCnt == BCW'(DATA_WIDTH - 1)) begin
                            r_bitCnt <= '0;
                            r_state  <= r_parEn ? PARITY : STOP;
                        end else begin
                            r_bitCnt <= r_bitCnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    r_edgeCnt <= w_edgeNext;
                    if (w_midBit) begin
                        r_parFlag <= (w_rx != ((^r_shift) ^ r_parTyp));
                    end
                    if (w_bitEnd) begin
                        r_state <= STOP;
                    end
                end
                STOP: begin
                    r_edgeCnt <= w_edgeNext;
                    if (w_midBit && !w_rx) begin
                        r_stpFlag <= 1'b1;
                    end
                    // Any error keeps the previous good word on P_DATA.
                    if (w_bitEnd) begin
                        r_state <= IDLE;
                        if (!r_parFlag && !r_stpFlag) begin
                            P_DATA     <= r_shift;
                            DATA_VALID <= 1'b1;
                        end else begin
                            PAR_ERR <= r_parFlag;
                            STP_ERR <= r_stpFlag;
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_edgeCnt <= 6'd0;
                    r_bitCnt  <= '0;
                end
            endcase
        end
    end

endmodule
